// File: rtl/reflet_float_compare_seq.sv
// Bit-serial sign-magnitude float comparator: sign check, then an MSB-first magnitude scan.
// Optional NaN detection (unordered flag) is enabled by defining REFLET_FLOAT_NAN_EN.
module reflet_float_compare_seq #(
  parameter int float_size    = 32,
  parameter int exponent_size = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [float_size-1:0] a,
  input  logic [float_size-1:0] b,
  output logic                  ready,
  output logic                  valid_out,
  output logic                  lt,
  output logic                  eq,
  output logic                  gt,
  output logic                  unordered
);
  localparam int iw = $clog2(float_size-1);

  typedef enum logic [1:0] {IDLE, SIGN, SCAN, DONE} state_t;

  if (exponent_size < 1 || exponent_size > float_size-2) begin : g_bad_param
    $error("exponent_size must leave room for sign and mantissa");
  end

  state_t                state;
  logic [float_size-1:0] ra, rb;
  logic [iw-1:0]         idx;
  logic                  sa, sb, mag_zero, abit, bbit;

  assign sa       = ra[float_size-1];
  assign sb       = rb[float_size-1];
  assign mag_zero = ~|ra[float_size-2:0] && ~|rb[float_size-2:0];
  assign abit     = ra[idx];
  assign bbit     = rb[idx];

`ifdef REFLET_FLOAT_NAN_EN
  logic unord_q;
  assign unordered = unord_q;

  function automatic logic is_nan(input logic [float_size-1:0] x);
    return (&x[float_size-2 -: exponent_size]) && (|x[float_size-2-exponent_size:0]);
  endfunction
`else
  assign unordered = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      valid_out <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      ra        <= '0;
      rb        <= '0;
      idx       <= '0;
`ifdef REFLET_FLOAT_NAN_EN
      unord_q   <= 1'b0;
`endif
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ra    <= a;
          rb    <= b;
          lt    <= 1'b0;
          eq    <= 1'b0;
          gt    <= 1'b0;
`ifdef REFLET_FLOAT_NAN_EN
          unord_q <= 1'b0;
`endif
          idx   <= iw'(float_size-2);
          ready <= 1'b0;
          state <= SIGN;
        end
        SIGN: begin
`ifdef REFLET_FLOAT_NAN_EN
          if (is_nan(ra) || is_nan(rb)) begin
            unord_q   <= 1'b1;
            valid_out <= 1'b1;
            state     <= DONE;
          end else
`endif
          if (mag_zero) begin
            // +0 and -0 compare equal regardless of sign
            eq        <= 1'b1;
            valid_out <= 1'b1;
            state     <= DONE;
          end else if (sa != sb) begin
            gt        <= ~sa;
            lt        <= sa;
            valid_out <= 1'b1;
            state     <= DONE;
          end else begin
            state <= SCAN;
          end
        end
        SCAN: begin
          if (abit != bbit) begin
            // negative operands: larger magnitude means smaller value
            gt        <= abit ^ sa;
            lt        <= ~(abit ^ sa);
            valid_out <= 1'b1;
            state     <= DONE;
          end else if (idx == '0) begin
            eq        <= 1'b1;
            valid_out <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reflet_float_compare_seq.sv
// Self-checking bench: directed vector table, corner sequences, and randomized compares
// against a value-level sign-magnitude reference model.
module tb_reflet_float_compare_seq;
  localparam int FS = 32;
  localparam int ES = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [FS-1:0] a = '0, b = '0;
  logic          ready, valid_out, lt, eq, gt, unordered;

  reflet_float_compare_seq #(.float_size(FS), .exponent_size(ES)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .ready(ready), .valid_out(valid_out), .lt(lt), .eq(eq), .gt(gt),
    .unordered(unordered)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  localparam logic [3:0] F_UN = 4'b1000, F_LT = 4'b0100, F_EQ = 4'b0010, F_GT = 4'b0001;

  typedef struct {
    logic [FS-1:0] a;
    logic [FS-1:0] b;
    logic [3:0]    fl;
    int            lat;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {unordered, lt, eq, gt};
  endfunction

  function automatic logic is_nan(input logic [FS-1:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  // Reference: compare values, then derive latency from where the decision falls.
  task automatic model(input logic [FS-1:0] x, input logic [FS-1:0] y,
                       output logic [3:0] fl, output int lat);
    logic [FS-2:0] mx, my, d;
    int hi;
    mx = x[FS-2:0];
    my = y[FS-2:0];
    lat = 1;
`ifdef REFLET_FLOAT_NAN_EN
    if (is_nan(x) || is_nan(y)) begin fl = F_UN; return; end
`endif
    if (mx == 0 && my == 0) begin fl = F_EQ; return; end
    if (x[FS-1] != y[FS-1]) begin fl = x[FS-1] ? F_LT : F_GT; return; end
    if (mx == my) begin fl = F_EQ; lat = FS; return; end
    if (x[FS-1] == 1'b0) fl = (mx > my) ? F_GT : F_LT;
    else                 fl = (mx > my) ? F_LT : F_GT;
    d  = mx ^ my;
    hi = 0;
    for (int i = 0; i < FS-1; i++) if (d[i]) hi = i;
    lat = 1 + (FS - 1 - hi);
  endtask

  // Accepts one comparison, scrambles the inputs afterwards, returns latency and flags.
  task automatic run_cmp(input logic [FS-1:0] ta, input logic [FS-1:0] tb_,
                         output int lat, output logic [3:0] fl);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 100) begin @(negedge clk); guard++; end
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    while (!valid_out && lat < 100) begin @(posedge clk); #1; lat++; end
    fl = flags();
  endtask

  task automatic check_cmp(input string nm, input logic [FS-1:0] ta, input logic [FS-1:0] tb_,
                           input logic [3:0] efl, input int elat);
    int lat;
    logic [3:0] fl;
    run_cmp(ta, tb_, lat, fl);
    chk({nm, " latency"}, lat, elat);
    chk({nm, " flags"}, fl, efl);
    @(posedge clk); #1;
    chk({nm, " pulse+ready"}, {valid_out, ready}, 2'b01);
    chk({nm, " hold"}, flags(), efl);
  endtask

  initial begin
    logic [3:0] efl;
    int elat, lat, cyc;
    logic [3:0] fl;
    logic [FS-1:0] ra, rb, m;
    logic rdy_bad;
    int vcyc[$];

    tbl[0] = '{32'h3F800000, 32'h40000000, F_LT, 2};
    tbl[1] = '{32'hBF800000, 32'h3F800000, F_LT, 1};
    tbl[2] = '{32'h00000000, 32'h80000000, F_EQ, 1};
    tbl[3] = '{32'h3F800001, 32'h3F800001, F_EQ, 32};
    tbl[4] = '{32'hC0000000, 32'hBF800000, F_LT, 2};
`ifdef REFLET_FLOAT_NAN_EN
    tbl[5] = '{32'h7FC00000, 32'h3F800000, F_UN, 1};
`else
    tbl[5] = '{32'h7FC00000, 32'h3F800000, F_GT, 2};
`endif
    tbl[6] = '{32'h3F800000, 32'h3F800001, F_LT, 32};
    tbl[7] = '{32'h80000000, 32'h80000000, F_EQ, 1};
    tbl[8] = '{32'h40000000, 32'hC0000000, F_GT, 1};
    tbl[9] = '{32'hBF800001, 32'hBF800000, F_LT, 32};

    #12;
    chk("reset outputs", {ready, valid_out, flags()}, 6'b100000);
    @(negedge clk); reset = 1'b1;

    for (int i = 0; i < 10; i++)
      check_cmp($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].fl, tbl[i].lat);

    // start during a full scan must be ignored and must not disturb the operands
    @(negedge clk);
    a = 32'h3F800001; b = 32'h3F800001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rdy_bad = 1'b0; lat = 0;
    while (!valid_out && lat < 100) begin
      if (ready) rdy_bad = 1'b1;
      if (lat == 4) begin @(negedge clk); start = 1'b1; a = 32'h0; b = 32'hFFFFFFFF; end
      @(posedge clk); #1; lat++;
      start = 1'b0;
    end
    chk("busy ready low", rdy_bad, 1'b0);
    chk("busy latency", lat, 32);
    chk("busy flags", flags(), F_EQ);
    for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
    chk("busy no requeue", {valid_out, ready, flags()}, {2'b01, F_EQ});

    // asynchronous reset mid-comparison
    @(negedge clk);
    a = 32'hC0000000; b = 32'hBF800000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; reset = 1'b0; #1;
    chk("midreset outputs", {ready, valid_out, flags()}, 6'b100000);
    @(posedge clk); #1;
    chk("midreset held", {ready, valid_out, flags()}, 6'b100000);
    reset = 1'b1;
    rdy_bad = 1'b0;
    for (int k = 0; k < 5; k++) begin @(posedge clk); #1; if (valid_out || !ready) rdy_bad = 1'b1; end
    chk("midreset idle", rdy_bad, 1'b0);

    // start held high: a new comparison every third edge for a SIGN-decided pair
    @(negedge clk);
    a = 32'h3F800000; b = 32'hBF800000; start = 1'b1;
    @(posedge clk); #1;
    for (cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (valid_out) vcyc.push_back(cyc);
    end
    start = 1'b0;
    chk("held count", vcyc.size(), 3);
    if (vcyc.size() == 3) chk("held spacing", {vcyc[0], vcyc[1], vcyc[2]}, {32'd1, 32'd4, 32'd7});
    chk("held flags", flags(), F_GT);

    // randomized operands against the model
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = $urandom;
        1: rb = ra;
        2: rb = ra ^ (32'h1 << $urandom_range(0, 30));
        3: begin ra = {ra[31], 31'h0}; rb = {1'($urandom), 31'h0}; end
        4: begin m = (32'h1 << $urandom_range(1, 30)) - 1; rb = ra ^ ($urandom & m); end
        default: begin ra = {ra[31], 8'hFF, ra[22:0]}; rb = (i % 2) ? $urandom : ra; end
      endcase
      model(ra, rb, efl, elat);
      run_cmp(ra, rb, lat, fl);
      chk($sformatf("rand%0d %h/%h latency", i, ra, rb), lat, elat);
      chk($sformatf("rand%0d %h/%h flags", i, ra, rb), fl, efl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
